instr_fetch_buffer: RTL and testbench

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/rv32_fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/instr_fetch_buffer.sv | 107 ++++++++++
 tb/tb_instr_fetch_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_fetch_pkg.sv
// Shared constants and the queue entry type for the instruction fetch buffer.
package rv32_fetch_pkg;

  localparam int unsigned XLEN = 32;

  // add x0,x0,x0 -- presented downstream whenever no instruction is valid
  localparam logic [XLEN-1:0] NOP = 32'h0000_0033;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: circular buffer with push, pop and a same-edge flush.
module fetch_fifo
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  fetch_entry_t    push_data_i,
  input  logic            pop_i,
  output fetch_entry_t    head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  fetch_entry_t    mem_q [Depth];
  fetch_entry_t    mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

  // Next-state for pointers, occupancy and storage; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rst_i || flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register; entry contents need no reset.
  always_ff @(posedge clk_i) begin
    mem_q    <= mem_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // The fetch credit rule must make a push into a full queue unreachable.
  push_on_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o))
    else $error("fetch_fifo: push while full");

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch unit: credit-limited prefetch into a small queue, with
// epoch tagging so responses issued before a redirect are dropped.
module instr_fetch_buffer
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic            inflight_epoch_q, inflight_epoch_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            epoch_q, epoch_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [XLEN-1:0] last_pc4_q, last_pc4_d;

  logic [CntW-1:0] count;
  logic [CntW:0]   occupancy;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  // Request, push and pop qualification plus the downstream view of the head.
  always_comb begin
    occupancy = {1'b0, count} + (CntW + 1)'(inflight_q);
    imem_req  = !rst && !redirect && (occupancy < (CntW + 1)'(DEPTH));
    imem_addr = fetch_pc_q;
    push      = !rst && !redirect && inflight_q && imem_valid &&
                (inflight_epoch_q == epoch_q);
    push_data = '{pc: inflight_pc_q, inst: imem_rdata};
    out_valid = !rst && !redirect && !fifo_empty;
    pop       = out_valid && !stall;
    out_inst  = out_valid ? head.inst : NOP;
    out_pc    = out_valid ? head.pc : last_pc_q;
    out_pc4   = out_valid ? head.pc + 32'd4 : last_pc4_q;
  end

  // Next-state for PC, epoch and in-flight tracking; reset over redirect over fetch.
  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    epoch_d          = epoch_q;
    inflight_d       = imem_req;
    inflight_epoch_d = epoch_q;
    inflight_pc_d    = fetch_pc_q;
    last_pc_d        = out_pc;
    last_pc4_d       = out_pc4;
    if (rst) begin
      fetch_pc_d = RESET_PC;
      epoch_d    = 1'b0;
      inflight_d = 1'b0;
      last_pc_d  = '0;
      last_pc4_d = '0;
    end else if (redirect) begin
      fetch_pc_d = redirect_pc;
      epoch_d    = !epoch_q;
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    fetch_pc_q       <= fetch_pc_d;
    epoch_q          <= epoch_d;
    inflight_q       <= inflight_d;
    inflight_epoch_q <= inflight_epoch_d;
    inflight_pc_q    <= inflight_pc_d;
    last_pc_q        <= last_pc_d;
    last_pc4_q       <= last_pc4_d;
  end

  fetch_fifo #(
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (redirect),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench: fill, stall/credit, redirect, back-to-back redirect, PC wrap, reset.
module tb_instr_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        b_redirect = 1'b0;

  logic        a_req, a_valid, a_out_valid;
  logic [31:0] a_addr, a_rdata, a_inst, a_pc, a_pc4;
  logic        b_req, b_valid, b_out_valid;
  logic [31:0] b_addr, b_rdata, b_inst, b_pc, b_pc4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .imem_req(a_req), .imem_addr(a_addr), .imem_valid(a_valid),
    .imem_rdata(a_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(a_out_valid), .out_inst(a_inst), .out_pc(a_pc), .out_pc4(a_pc4)
  );

  instr_fetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr), .imem_valid(b_valid),
    .imem_rdata(b_rdata), .redirect(b_redirect), .redirect_pc(32'h0), .stall(stall),
    .out_valid(b_out_valid), .out_inst(b_inst), .out_pc(b_pc), .out_pc4(b_pc4)
  );

  // One-cycle-latency memories returning addr | 0xA000.
  always @(posedge clk) begin
    a_valid <= a_req;
    a_rdata <= a_addr | 32'h0000_A000;
    b_valid <= b_req;
    b_rdata <= b_addr | 32'h0000_A000;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance to the next cycle window; outputs are settled by return.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    stall = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int nreq;
    logic [31:0] e;

    // Reset state and initial fill, plus wrap on the second instance.
    step();
    step();
    check_eq("rst_valid", {31'b0, a_out_valid}, 32'd0);
    check_eq("rst_inst", a_inst, 32'h0000_0033);
    check_eq("rst_pc", a_pc, 32'd0);
    check_eq("rst_pc4", a_pc4, 32'd0);
    check_eq("rst_req", {31'b0, a_req}, 32'd0);
    rst = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      check_eq("fill_req", {31'b0, a_req}, 32'd1);
      check_eq("fill_addr", a_addr, 32'(4 * c));
      if (c < 2) begin
        check_eq("fill_nvalid", {31'b0, a_out_valid}, 32'd0);
      end else begin
        e = 32'(4 * (c - 2));
        check_eq("fill_valid", {31'b0, a_out_valid}, 32'd1);
        check_eq("fill_pc", a_pc, e);
        check_eq("fill_inst", a_inst, e | 32'h0000_A000);
      end
      if (c < 4) begin
        e = 32'hFFFF_FFF8 + 32'(4 * c);
        check_eq("wrap_addr", b_addr, e);
      end
      if (c == 3) begin
        check_eq("wrap_pc", b_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", b_pc4, 32'h0000_0000);
      end
    end

    // Stall: credit limits issue to DEPTH, then release drains in order.
    do_reset();
    stall = 1'b1;
    #1;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      if (a_req) begin
        check_eq("stall_addr", a_addr, 32'(4 * nreq));
        nreq++;
      end
    end
    check_eq("stall_nreq", 32'(nreq), 32'd4);
    check_eq("stall_req_off", {31'b0, a_req}, 32'd0);
    check_eq("stall_head", a_pc, 32'd0);
    step();
    stall = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      check_eq("drain_valid", {31'b0, a_out_valid}, 32'd1);
      check_eq("drain_pc", a_pc, 32'(4 * k));
    end

    // Redirect while the 0x10 response is in flight.
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check_eq("pre_redir_addr", a_addr, 32'h10);
    check_eq("pre_redir_pc", a_pc, 32'h8);
    step();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check_eq("redir_valid", {31'b0, a_out_valid}, 32'd0);
    check_eq("redir_req", {31'b0, a_req}, 32'd0);
    step();
    redirect = 1'b0;
    #1;
    check_eq("redir1_req", {31'b0, a_req}, 32'd1);
    check_eq("redir1_addr", a_addr, 32'h100);
    check_eq("redir1_valid", {31'b0, a_out_valid}, 32'd0);
    check_eq("redir1_pc_hold", a_pc, 32'h8);
    check_eq("redir1_pc4_hold", a_pc4, 32'hC);
    step();
    check_eq("redir2_valid", {31'b0, a_out_valid}, 32'd0);
    step();
    check_eq("redir3_valid", {31'b0, a_out_valid}, 32'd1);
    check_eq("redir3_pc", a_pc, 32'h100);
    check_eq("redir3_pc4", a_pc4, 32'h104);
    check_eq("redir3_inst", a_inst, 32'h0000_A100);
    step();
    check_eq("redir4_pc", a_pc, 32'h104);

    // Back-to-back redirects: only the last target is fetched.
    step();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #1;
    check_eq("bb0_req", {31'b0, a_req}, 32'd0);
    step();
    redirect_pc = 32'h300;
    #1;
    check_eq("bb1_req", {31'b0, a_req}, 32'd0);
    check_eq("bb1_valid", {31'b0, a_out_valid}, 32'd0);
    step();
    redirect = 1'b0;
    #1;
    check_eq("bb2_addr", a_addr, 32'h300);
    check_eq("bb2_valid", {31'b0, a_out_valid}, 32'd0);
    step();
    check_eq("bb3_valid", {31'b0, a_out_valid}, 32'd0);
    step();
    check_eq("bb4_valid", {31'b0, a_out_valid}, 32'd1);
    check_eq("bb4_pc", a_pc, 32'h300);

    // Reset mid-stream with three entries queued.
    do_reset();
    stall = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) step();
    check_eq("mid_head", a_pc, 32'h0);
    rst = 1'b1;
    #1;
    step();
    check_eq("mid_rst_valid", {31'b0, a_out_valid}, 32'd0);
    check_eq("mid_rst_inst", a_inst, 32'h0000_0033);
    check_eq("mid_rst_pc", a_pc, 32'd0);
    check_eq("mid_rst_pc4", a_pc4, 32'd0);
    rst = 1'b0;
    stall = 1'b0;
    #1;
    check_eq("mid_rel_req", {31'b0, a_req}, 32'd1);
    check_eq("mid_rel_addr", a_addr, 32'h0);
    step();
    check_eq("mid_rel1_valid", {31'b0, a_out_valid}, 32'd0);
    step();
    check_eq("mid_rel2_valid", {31'b0, a_out_valid}, 32'd1);
    check_eq("mid_rel2_pc", a_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
